// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: bridges the core's zero-latency fetch port to a
// variable-latency backing RAM over a req/ack handshake, with stall hold and clear bubbles.
module imem_fetch_responder #(
    parameter logic [31:0] MEM_BASE  = 32'h80020000,
    parameter logic [31:0] MEM_DEPTH = 32'h00100000,
    parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_addr,
    input  logic        instr_stall,
    input  logic        instr_clear,
    output logic [31:0] instr_out,
    output logic        instr_wait,
    output logic        fetch_err,
    output logic        bk_req,
    output logic [31:0] bk_addr,
    input  logic        bk_ack,
    input  logic [31:0] bk_rdata,
    output logic [31:0] fetch_cnt,
    output logic [31:0] wait_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] addr_q;
    logic        addr_ok;
    logic        issue;
    logic        bk_req_raw;
    logic        load_data;
    logic        load_nop;
    logic        latch_addr;
    logic        count_fetch;
    logic        count_wait;
    logic        err_pulse;
    logic [32:0] addr_ext;
    logic [32:0] win_lo;
    logic [32:0] win_hi;

    // 33-bit window bounds so MEM_BASE+MEM_DEPTH cannot wrap to zero
    assign addr_ext = {1'b0, instr_addr};
    assign win_lo   = {1'b0, MEM_BASE};
    assign win_hi   = {1'b0, MEM_BASE} + {1'b0, MEM_DEPTH};
    assign addr_ok  = (instr_addr[1:0] == 2'b00) && (addr_ext >= win_lo) && (addr_ext < win_hi);
    assign issue    = ~instr_stall & addr_ok;

    assign instr_wait = (state == ST_WAIT);
    assign bk_req     = bk_req_raw & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        bk_req_raw  = 1'b0;
        bk_addr     = instr_addr;
        load_data   = 1'b0;
        load_nop    = 1'b0;
        latch_addr  = 1'b0;
        count_fetch = 1'b0;
        count_wait  = 1'b0;
        err_pulse   = 1'b0;
        case (state)
            ST_IDLE: begin
                bk_req_raw = issue;
                // Address 0 is the program-exit return target and faults silently
                err_pulse  = ~instr_stall & ~addr_ok & (instr_addr != 32'h0);
                if (instr_clear) begin
                    load_nop = 1'b1;
                    if (issue && !bk_ack) begin
                        latch_addr = 1'b1;
                        state_next = ST_DRAIN;
                    end
                end else if (!instr_stall) begin
                    if (addr_ok) begin
                        if (bk_ack) begin
                            load_data   = 1'b1;
                            count_fetch = 1'b1;
                        end else begin
                            latch_addr = 1'b1;
                            state_next = ST_WAIT;
                        end
                    end else begin
                        load_nop = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                bk_req_raw = 1'b1;
                bk_addr    = addr_q;
                count_wait = 1'b1;
                if (instr_clear) begin
                    load_nop   = 1'b1;
                    state_next = bk_ack ? ST_IDLE : ST_DRAIN;
                end else if (bk_ack) begin
                    load_data   = 1'b1;
                    count_fetch = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Squashed fetch: finish the handshake, throw the data away
                bk_req_raw = 1'b1;
                bk_addr    = addr_q;
                if (bk_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_out <= NOP_WORD;
            addr_q    <= 32'h0;
            fetch_err <= 1'b0;
            fetch_cnt <= 32'h0;
            wait_cnt  <= 32'h0;
        end else begin
            fetch_err <= err_pulse;
            if (load_nop) begin
                instr_out <= NOP_WORD;
            end else if (load_data) begin
                instr_out <= bk_rdata;
            end
            if (latch_addr) begin
                addr_q <= instr_addr;
            end
            if (count_fetch) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (count_wait) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: the bench plays the backing RAM by
// driving bk_ack/bk_rdata by hand and checks against hand-computed values.
module tb_imem_fetch_responder;

    logic        clk;
    logic        reset;
    logic [31:0] instr_addr;
    logic        instr_stall;
    logic        instr_clear;
    logic [31:0] instr_out;
    logic        instr_wait;
    logic        fetch_err;
    logic        bk_req;
    logic [31:0] bk_addr;
    logic        bk_ack;
    logic [31:0] bk_rdata;
    logic [31:0] fetch_cnt;
    logic [31:0] wait_cnt;

    int total;
    int bad;

    imem_fetch_responder dut (
        .clk        (clk),
        .reset      (reset),
        .instr_addr (instr_addr),
        .instr_stall(instr_stall),
        .instr_clear(instr_clear),
        .instr_out  (instr_out),
        .instr_wait (instr_wait),
        .fetch_err  (fetch_err),
        .bk_req     (bk_req),
        .bk_addr    (bk_addr),
        .bk_ack     (bk_ack),
        .bk_rdata   (bk_rdata),
        .fetch_cnt  (fetch_cnt),
        .wait_cnt   (wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b0;
        instr_addr  = 32'h0;
        instr_stall = 1'b0;
        instr_clear = 1'b0;
        bk_ack      = 1'b0;
        bk_rdata    = 32'h0;
        #1;
        chk("rst_out", instr_out, 32'h0);
        chk("rst_req", {31'h0, bk_req}, 32'h0);
        chk("rst_wait", {31'h0, instr_wait}, 32'h0);
        chk("rst_err", {31'h0, fetch_err}, 32'h0);
        chk("rst_fcnt", fetch_cnt, 32'h0);
        chk("rst_wcnt", wait_cnt, 32'h0);
        tick();
        tick();
        #3 reset = 1'b1;
        tick();

        // zero-wait fetch
        instr_addr = 32'h80020000;
        bk_ack     = 1'b1;
        bk_rdata   = 32'h27bdffe8;
        #1;
        chk("zw_req", {31'h0, bk_req}, 32'h1);
        chk("zw_addr", bk_addr, 32'h80020000);
        chk("zw_wait0", {31'h0, instr_wait}, 32'h0);
        tick();
        chk("zw_out", instr_out, 32'h27bdffe8);
        chk("zw_fcnt", fetch_cnt, 32'd1);
        chk("zw_wait1", {31'h0, instr_wait}, 32'h0);

        // three-cycle delayed ack
        instr_addr = 32'h80020004;
        bk_ack     = 1'b0;
        tick();
        chk("dl_wait_c1", {31'h0, instr_wait}, 32'h1);
        chk("dl_out_hold", instr_out, 32'h27bdffe8);
        instr_addr = 32'h80020010;
        instr_stall = 1'b1;
        #1;
        chk("dl_addr_c1", bk_addr, 32'h80020004);
        chk("dl_req_c1", {31'h0, bk_req}, 32'h1);
        tick();
        chk("dl_wait_c2", {31'h0, instr_wait}, 32'h1);
        chk("dl_addr_c2", bk_addr, 32'h80020004);
        tick();
        bk_ack   = 1'b1;
        bk_rdata = 32'h00851021;
        #1;
        chk("dl_wait_c3", {31'h0, instr_wait}, 32'h1);
        chk("dl_addr_c3", bk_addr, 32'h80020004);
        tick();
        chk("dl_out", instr_out, 32'h00851021);
        chk("dl_wait_end", {31'h0, instr_wait}, 32'h0);
        chk("dl_wcnt", wait_cnt, 32'd3);
        chk("dl_fcnt", fetch_cnt, 32'd2);

        // stall holds output and suppresses requests
        bk_ack     = 1'b0;
        instr_addr = 32'h80020008;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("st_req", {31'h0, bk_req}, 32'h0);
            tick();
            chk("st_out", instr_out, 32'h00851021);
        end
        chk("st_fcnt", fetch_cnt, 32'd2);

        // clear during WAIT
        instr_stall = 1'b0;
        tick();
        chk("cl_wait_in", {31'h0, instr_wait}, 32'h1);
        instr_clear = 1'b1;
        tick();
        instr_clear = 1'b0;
        instr_addr  = 32'h8002000c;
        #1;
        chk("cl_out_nop", instr_out, 32'h0);
        chk("cl_wait_drop", {31'h0, instr_wait}, 32'h0);
        chk("cl_req_hold", {31'h0, bk_req}, 32'h1);
        chk("cl_addr_hold", bk_addr, 32'h80020008);
        tick();
        chk("cl_req_hold2", {31'h0, bk_req}, 32'h1);
        bk_ack   = 1'b1;
        bk_rdata = 32'hdeadbeef;
        tick();
        bk_ack      = 1'b0;
        instr_stall = 1'b1;
        chk("cl_out_discard", instr_out, 32'h0);
        chk("cl_fcnt", fetch_cnt, 32'd2);
        chk("cl_wcnt", wait_cnt, 32'd4);
        #1;
        chk("cl_req_idle", {31'h0, bk_req}, 32'h0);

        // fault handling
        instr_stall = 1'b0;
        instr_addr  = 32'h80020000;
        bk_ack      = 1'b1;
        bk_rdata    = 32'h11111111;
        tick();
        chk("ft_pre_out", instr_out, 32'h11111111);
        bk_ack     = 1'b0;
        instr_addr = 32'h80020002;
        #1;
        chk("ft_mis_req", {31'h0, bk_req}, 32'h0);
        tick();
        chk("ft_mis_err", {31'h0, fetch_err}, 32'h1);
        chk("ft_mis_out", instr_out, 32'h0);
        instr_addr = 32'h00000000;
        tick();
        chk("ft_zero_err", {31'h0, fetch_err}, 32'h0);
        chk("ft_zero_out", instr_out, 32'h0);
        instr_addr = 32'h8011fffc;
        #1;
        chk("ft_last_req", {31'h0, bk_req}, 32'h1);
        instr_addr = 32'h8001fffc;
        #1;
        chk("ft_below_req", {31'h0, bk_req}, 32'h0);
        instr_addr = 32'h80120000;
        #1;
        chk("ft_top_req", {31'h0, bk_req}, 32'h0);
        tick();
        chk("ft_top_err", {31'h0, fetch_err}, 32'h1);
        instr_addr = 32'h0;
        tick();
        chk("ft_err_pulse", {31'h0, fetch_err}, 32'h0);
        chk("ft_fcnt", fetch_cnt, 32'd3);

        // async reset mid-WAIT
        instr_addr = 32'h80020004;
        tick();
        chk("rs_wait_in", {31'h0, instr_wait}, 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("rs_out", instr_out, 32'h0);
        chk("rs_req", {31'h0, bk_req}, 32'h0);
        chk("rs_wait", {31'h0, instr_wait}, 32'h0);
        chk("rs_fcnt", fetch_cnt, 32'h0);
        chk("rs_wcnt", wait_cnt, 32'h0);
        #1 reset = 1'b1;
        instr_addr = 32'h80020000;
        bk_ack     = 1'b1;
        bk_rdata   = 32'h27bdffe8;
        tick();
        chk("rs_post_out", instr_out, 32'h27bdffe8);
        chk("rs_post_fcnt", fetch_cnt, 32'd1);
        bk_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Responder end of the processor's instruction-fetch interface (instr_addr / instr_stall / instr_clear -> instr_in). Replaces the zero-latency instruction memory model with a bridge to a variable-latency backing RAM over a req/ack handshake.
- Holds its output on stall and injects NOP bubbles on clear.
- Tells the core to freeze via instr_wait while a fetch is outstanding.
- Keeps delivered-fetch and wait-cycle counters for benchmark reporting.

Parameters:
- MEM_BASE, 32'h80020000, lowest fetchable byte address.
- MEM_DEPTH, 32'h00100000, fetchable window size in bytes.
- NOP_WORD, 32'h00000000, word driven on clear, reset and faults.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- instr_addr  in  32  fetch byte address from core PC.
- instr_stall  in  1  core holds fetch; no new request, output held.
- instr_clear  in  1  squash; next instr_out is NOP_WORD.
- instr_out  out  32  registered instruction to core (drives its instr_in).
- instr_wait  out  1  fetch outstanding; core must freeze PC and IF/ID.
- fetch_err  out  1  one-cycle pulse on misaligned or out-of-window fetch.
- bk_req  out  1  backing-RAM read request.
- bk_addr  out  32  backing-RAM word address (byte address, [1:0]=0).
- bk_ack  in  1  backing-RAM read complete; bk_rdata valid this cycle.
- bk_rdata  in  32  backing-RAM read data.
- fetch_cnt  out  32  instructions delivered (NOP injections excluded).
- wait_cnt  out  32  cycles spent with instr_wait=1.

Behaviour:
- Reset (reset=0, async): state=IDLE, instr_out=NOP_WORD, fetch_err=0, counters=0. bk_req is forced 0 while reset is low.
- States: IDLE, WAIT, DRAIN. instr_wait = (state==WAIT).
- bk_req = (IDLE & ~instr_stall & addr_ok) | WAIT | DRAIN.
- bk_addr = instr_addr in IDLE; latched addr_q in WAIT and DRAIN.
- addr_ok = instr_addr[1:0]==0 & MEM_BASE <= instr_addr < MEM_BASE+MEM_DEPTH. Compare in 33 bits so the upper bound cannot wrap.
- IDLE, instr_stall=1: no request; instr_out holds.
- IDLE, request issued:
  - bk_ack=1 same cycle: instr_out <= bk_rdata at that edge (1-cycle latency, identical to a synchronous memory); fetch_cnt++.
  - bk_ack=0: addr_q <= instr_addr; go to WAIT.
- IDLE, ~instr_stall & ~addr_ok: no request; instr_out <= NOP_WORD.
  - fetch_err pulses for one cycle, except when instr_addr==0. Address 0 is the program-exit return target and is silent.
- WAIT: bk_req held high, bk_addr=addr_q; instr_addr and instr_stall are ignored. wait_cnt++ each cycle.
  - On bk_ack: instr_out <= bk_rdata; fetch_cnt++; go to IDLE.
- Clear has priority over stall and over data, evaluated at each edge:
  - instr_out <= NOP_WORD.
  - IDLE request acked same cycle: data discarded, no count.
  - IDLE request not acked, or state WAIT: go to DRAIN. The handshake must complete; bk_req stays high.
  - DRAIN: instr_wait=0; the core may run, fed NOPs. On bk_ack: data discarded; go to IDLE.
  - Clear in DRAIN: no effect.
- Backing RAM must keep bk_rdata stable only in the ack cycle. bk_req never drops before ack, even for clear.
- Counters wrap modulo 2^32.
- Reset asserted mid-WAIT or mid-DRAIN abandons the transaction. The backing RAM must tolerate a dropped request.

Test Plan:
- Zero-wait backing (bk_ack tied 1), instr_addr=32'h80020000, RAM word 32'h27bdffe8 -> instr_out=32'h27bdffe8 one edge later; instr_wait never 1; fetch_cnt=1.
- bk_ack delayed 3 cycles at 32'h80020004 -> instr_wait=1 for exactly 3 cycles; bk_addr stable at 32'h80020004; instr_out updated at the ack edge; wait_cnt=3.
- instr_stall=1 for 4 cycles after a delivered word 32'h00851021 -> bk_req=0; instr_out stays 32'h00851021.
- instr_clear during WAIT at 32'h80020008 -> instr_out=32'h00000000 next edge; instr_wait drops; bk_req held until ack; acked data never appears; fetch_cnt unchanged.
- instr_addr=32'h80020002 -> no bk_req, fetch_err 1-cycle pulse, instr_out=NOP. instr_addr=32'h00000000 -> NOP, fetch_err=0. instr_addr=MEM_BASE+MEM_DEPTH -> fault.
- reset=0 asserted mid-WAIT -> instr_out=NOP, bk_req=0, counters=0 immediately (asynchronous). After release, a fetch of 32'h80020000 completes normally.
